// File: rtl/instr_breakdown_pipe.sv
// RV32I/RV64I instruction breakdown: field split, immediate generation,
// format/legality classification, and a DEPTH-stage valid/stall/flush pipe.
module instr_breakdown_pipe #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 2,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               in_ready,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  output logic [6:0]         opcode,
  output logic [2:0]         func3,
  output logic [6:0]         func7,
  output logic [4:0]         rd,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [XLEN-1:0]    imm,
  output logic [2:0]         fmt,
  output logic               illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       op_r, op_i, op_s, op_b, op_u, op_j;
  logic       sh_z;

  assign opc  = instr[6:0];
  assign f3   = instr[14:12];
  assign op_r = (opc == 7'b0110011);
  assign op_i = (opc == 7'b0010011) || (opc == 7'b0000011) ||
                (opc == 7'b1100111) || (opc == 7'b1110011);
  assign op_s = (opc == 7'b0100011);
  assign op_b = (opc == 7'b1100011);
  assign op_u = (opc == 7'b0110111) || (opc == 7'b0010111);
  assign op_j = (opc == 7'b1101111);
  // shift-immediates carry an unsigned shamt/func7 field
  assign sh_z = (opc == 7'b0010011) &&
                ((f3 == 3'b001) || (f3 == 3'b101));

  logic [XLEN-1:0] imm_d;
  logic [2:0]      fmt_d;
  logic            ill_d;

  always_comb begin
    imm_d = '0;
    fmt_d = 3'd7;
    ill_d = 1'b0;
    unique case (1'b1)
      op_r: fmt_d = 3'd0;
      op_i: begin
        fmt_d = 3'd1;
        imm_d = sh_z ? XLEN'(instr[31:20])
                     : XLEN'($signed(instr[31:20]));
      end
      op_s: begin
        fmt_d = 3'd2;
        imm_d = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      op_b: begin
        fmt_d = 3'd3;
        imm_d = XLEN'($signed({instr[31], instr[7],
                               instr[30:25], instr[11:8],
                               1'b0}));
      end
      op_u: begin
        fmt_d = 3'd4;
        imm_d = XLEN'($signed({instr[31:12], 12'b0}));
      end
      op_j: begin
        fmt_d = 3'd5;
        imm_d = XLEN'($signed({instr[31], instr[19:12],
                               instr[20], instr[30:21],
                               1'b0}));
      end
      default: begin
        fmt_d = 3'd7;
        ill_d = 1'b1;
      end
    endcase
  end

  assign in_ready = !stall;

  for (genvar g = 0; g < DEPTH; g++) begin : g_st
    logic               v_q, v_d;
    logic [INSTR_W-1:0] ins_q, ins_d;
    logic [XLEN-1:0]    imm_q, imm_d2;
    logic [2:0]         fmt_q, fmt_d2;
    logic               ill_q, ill_d2;

    if (g == 0) begin : g_in
      assign v_d    = in_valid;
      assign ins_d  = instr;
      assign imm_d2 = imm_d;
      assign fmt_d2 = fmt_d;
      assign ill_d2 = ill_d;
    end else begin : g_sh
      assign v_d    = g_st[g-1].v_q;
      assign ins_d  = g_st[g-1].ins_q;
      assign imm_d2 = g_st[g-1].imm_q;
      assign fmt_d2 = g_st[g-1].fmt_q;
      assign ill_d2 = g_st[g-1].ill_q;
    end

    // data regs keep stale contents on flush; only valid is killed
    always_ff @(posedge clk) begin
      if (reset) begin
        v_q   <= 1'b0;
        ins_q <= '0;
        imm_q <= '0;
        fmt_q <= '0;
        ill_q <= 1'b0;
      end else if (flush) begin
        v_q <= 1'b0;
      end else if (!stall) begin
        v_q   <= v_d;
        ins_q <= ins_d;
        imm_q <= imm_d2;
        fmt_q <= fmt_d2;
        ill_q <= ill_d2;
      end
    end
  end

  assign out_valid = g_st[DEPTH-1].v_q;
  assign opcode    = g_st[DEPTH-1].ins_q[6:0];
  assign rd        = g_st[DEPTH-1].ins_q[11:7];
  assign func3     = g_st[DEPTH-1].ins_q[14:12];
  assign rs1       = g_st[DEPTH-1].ins_q[19:15];
  assign rs2       = g_st[DEPTH-1].ins_q[24:20];
  assign func7     = g_st[DEPTH-1].ins_q[31:25];
  assign imm       = g_st[DEPTH-1].imm_q;
  assign fmt       = g_st[DEPTH-1].fmt_q;
  assign illegal   = g_st[DEPTH-1].ill_q;

endmodule

// File: tb/tb_instr_breakdown_pipe.sv
// Bench for instr_breakdown_pipe: DEPTH=2/XLEN=32 and DEPTH=1/XLEN=64
// instances on shared stimulus, checked against a tick-history model.
module tb_instr_breakdown_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, stall, flush;
  logic [31:0] instr;

  logic        a_rdy, a_ov, a_ill;
  logic [6:0]  a_opc, a_f7;
  logic [2:0]  a_f3, a_fmt;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [31:0] a_imm;

  logic        b_rdy, b_ov, b_ill;
  logic [6:0]  b_opc, b_f7;
  logic [2:0]  b_f3, b_fmt;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [63:0] b_imm;

  instr_breakdown_pipe #(.XLEN(32), .DEPTH(2), .INSTR_W(32)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
    .in_ready(a_rdy), .stall(stall), .flush(flush),
    .out_valid(a_ov), .opcode(a_opc), .func3(a_f3), .func7(a_f7),
    .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2), .imm(a_imm),
    .fmt(a_fmt), .illegal(a_ill)
  );

  instr_breakdown_pipe #(.XLEN(64), .DEPTH(1), .INSTR_W(32)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
    .in_ready(b_rdy), .stall(stall), .flush(flush),
    .out_valid(b_ov), .opcode(b_opc), .func3(b_f3), .func7(b_f7),
    .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2), .imm(b_imm),
    .fmt(b_fmt), .illegal(b_ill)
  );

  // one history entry per advancing edge; z marks "known all-zero" data
  typedef struct {
    bit          v;
    bit          z;
    logic [31:0] ins;
  } ent_t;

  ent_t hq[2][$];
  int   dep[2] = '{2, 1};
  int   xl[2]  = '{32, 64};
  int   ncmp   = 0;
  int   nfail  = 0;

  localparam logic [31:0] ADDI = 32'hFFF10093;
  localparam logic [31:0] SLLI = 32'h01F19193;
  localparam logic [31:0] BEQ  = 32'hFE000EE3;
  localparam logic [31:0] LUI  = 32'h123452B7;
  localparam logic [31:0] BAD  = 32'h0000007F;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_fmt(logic [31:0] w);
    case (w[6:0])
      7'h33:                      return 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73: return 3'd1;
      7'h23:                      return 3'd2;
      7'h63:                      return 3'd3;
      7'h37, 7'h17:               return 3'd4;
      7'h6F:                      return 3'd5;
      default:                    return 3'd7;
    endcase
  endfunction

  function automatic logic [63:0] ref_imm(logic [31:0] w, int x);
    logic [63:0] v;
    v = 64'd0;
    case (ref_fmt(w))
      3'd1: begin
        v = 64'(w[31:20]);
        if (!(w[6:0] == 7'h13 && (w[14:12] == 3'd1 || w[14:12] == 3'd5))
            && w[31])
          v = v - 64'd4096;
      end
      3'd2: begin
        v = 64'(w[31:25]) * 32 + 64'(w[11:7]);
        if (w[31]) v = v - 64'd4096;
      end
      3'd3: begin
        v = 64'(w[31]) * 4096 + 64'(w[7]) * 2048 +
            64'(w[30:25]) * 32 + 64'(w[11:8]) * 2;
        if (w[31]) v = v - 64'd8192;
      end
      3'd4: begin
        v = 64'(w[31:12]) * 4096;
        if (w[31]) v = v - 64'h1_0000_0000;
      end
      3'd5: begin
        v = 64'(w[31]) * 1048576 + 64'(w[19:12]) * 4096 +
            64'(w[20]) * 2048 + 64'(w[30:21]) * 2;
        if (w[31]) v = v - 64'd2097152;
      end
      default: v = 64'd0;
    endcase
    if (x == 32) v[63:32] = 32'd0;
    return v;
  endfunction

  task automatic upd();
    ent_t e;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int i = 0; i < dep[k]; i++) begin
          e.v = 1'b0; e.z = 1'b1; e.ins = '0;
          hq[k].push_back(e);
        end
      end else if (flush) begin
        for (int i = 0; i < hq[k].size(); i++) begin
          hq[k][i].v = 1'b0;
          hq[k][i].z = 1'b0;
        end
        e.v = 1'b0; e.z = 1'b0; e.ins = '0;
        hq[k].push_back(e);
      end else if (!stall) begin
        e.v = in_valid; e.z = 1'b0; e.ins = instr;
        hq[k].push_back(e);
      end
      while (hq[k].size() > 16) void'(hq[k].pop_front());
    end
  endtask

  task automatic cmp(string nm, int k, logic ov, logic [63:0] im,
                     logic [2:0] fm, logic il, logic [6:0] op,
                     logic [2:0] f3, logic [6:0] f7, logic [4:0] d,
                     logic [4:0] s1, logic [4:0] s2);
    ent_t        e;
    logic [31:0] w;
    e = hq[k][hq[k].size() - dep[k]];
    chk({nm, ".out_valid"}, 64'(ov), 64'(e.v));
    if (e.v || e.z) begin
      w = e.z ? 32'd0 : e.ins;
      chk({nm, ".imm"}, im, e.z ? 64'd0 : ref_imm(w, xl[k]));
      chk({nm, ".fmt"}, 64'(fm), e.z ? 64'd0 : 64'(ref_fmt(w)));
      chk({nm, ".illegal"}, 64'(il),
          e.z ? 64'd0 : 64'(ref_fmt(w) == 3'd7));
      chk({nm, ".opcode"}, 64'(op), 64'(w[6:0]));
      chk({nm, ".rd"}, 64'(d), 64'(w[11:7]));
      chk({nm, ".func3"}, 64'(f3), 64'(w[14:12]));
      chk({nm, ".rs1"}, 64'(s1), 64'(w[19:15]));
      chk({nm, ".rs2"}, 64'(s2), 64'(w[24:20]));
      chk({nm, ".func7"}, 64'(f7), 64'(w[31:25]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    upd();
    #2;
    chk("a.in_ready", 64'(a_rdy), 64'(!stall));
    chk("b.in_ready", 64'(b_rdy), 64'(!stall));
    cmp("a", 0, a_ov, 64'(a_imm), a_fmt, a_ill, a_opc, a_f3, a_f7,
        a_rd, a_rs1, a_rs2);
    cmp("b", 1, b_ov, b_imm, b_fmt, b_ill, b_opc, b_f3, b_f7,
        b_rd, b_rs1, b_rs2);
  endtask

  logic [6:0]  ops [12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23,
                            7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h0B};
  logic [31:0] r, ri;

  initial begin
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    instr = '0;
    tick();
    chk("rst.a_fmt", 64'(a_fmt), 64'd0);
    chk("rst.b_imm", b_imm, 64'd0);
    reset = 1'b0;

    // single addi through both depths
    in_valid = 1'b1; instr = ADDI;
    tick();
    chk("t1.b_ov", 64'(b_ov), 64'd1);
    chk("t1.b_imm", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1.a_ov_early", 64'(a_ov), 64'd0);
    in_valid = 1'b0;
    tick();
    chk("t1.a_ov", 64'(a_ov), 64'd1);
    chk("t1.a_imm", 64'(a_imm), 64'hFFFF_FFFF);
    chk("t1.a_rd", 64'(a_rd), 64'd1);
    chk("t1.a_rs1", 64'(a_rs1), 64'd2);
    chk("t1.a_fmt", 64'(a_fmt), 64'd1);
    chk("t1.a_ill", 64'(a_ill), 64'd0);
    tick();

    // back-to-back
    in_valid = 1'b1; instr = SLLI; tick();
    instr = BEQ; tick();
    chk("t2.slli_imm", 64'(a_imm), 64'h1F);
    chk("t2.slli_fmt", 64'(a_fmt), 64'd1);
    instr = LUI; tick();
    chk("t2.beq_imm", 64'(a_imm), 64'hFFFF_FFFC);
    chk("t2.beq_fmt", 64'(a_fmt), 64'd3);
    in_valid = 1'b0; tick();
    chk("t2.lui_imm", 64'(a_imm), 64'h1234_5000);
    chk("t2.lui_rd", 64'(a_rd), 64'd5);
    chk("t2.lui_fmt", 64'(a_fmt), 64'd4);
    tick(); tick();

    // stall with beq at the last stage
    in_valid = 1'b1; instr = SLLI; tick();
    instr = BEQ; tick();
    instr = LUI; tick();
    instr = ADDI; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3.frozen_imm", 64'(a_imm), 64'hFFFF_FFFC);
      chk("t3.frozen_ov", 64'(a_ov), 64'd1);
    end
    stall = 1'b0; in_valid = 1'b0;
    tick();
    chk("t3.next_rd", 64'(a_rd), 64'd5);
    tick(); tick();

    // flush + stall together with two in flight
    in_valid = 1'b1; instr = SLLI; tick();
    instr = BEQ; tick();
    instr = LUI; flush = 1'b1; stall = 1'b1;
    tick();
    chk("t4.a_ov", 64'(a_ov), 64'd0);
    chk("t4.b_ov", 64'(b_ov), 64'd0);
    flush = 1'b0; stall = 1'b0; instr = ADDI;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t4.new_ov", 64'(a_ov), 64'd1);
    chk("t4.new_imm", 64'(a_imm), 64'hFFFF_FFFF);
    tick();

    // unsupported opcode
    in_valid = 1'b1; instr = BAD; tick();
    in_valid = 1'b0; tick();
    chk("t5.ill", 64'(a_ill), 64'd1);
    chk("t5.fmt", 64'(a_fmt), 64'd7);
    chk("t5.imm", 64'(a_imm), 64'd0);

    // mid-stream reset
    in_valid = 1'b1; instr = LUI; tick();
    instr = BEQ; tick();
    reset = 1'b1; tick();
    chk("t6.b_ov", 64'(b_ov), 64'd0);
    chk("t6.b_imm", b_imm, 64'd0);
    chk("t6.b_rd", 64'(b_rd), 64'd0);
    chk("t6.b_fmt", 64'(b_fmt), 64'd0);
    chk("t6.a_ov", 64'(a_ov), 64'd0);
    chk("t6.a_opc", 64'(a_opc), 64'd0);
    reset = 1'b0; in_valid = 1'b0;
    tick();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      r        = $urandom();
      ri       = $urandom();
      in_valid = r[0] | r[1];
      stall    = (r[4:2] == 3'd0);
      flush    = (r[7:5] == 3'd0);
      reset    = (r[15:10] == 6'd0);
      instr    = {ri[31:7], ops[$urandom_range(0, 11)]};
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
